// File: rtl/key_pulse_debouncer.sv
// key_pulse_debouncer: 2-flop synchronizer, debounce FSM and single-cycle press pulse.
// Auto-repeat while held is built only when KEY_PULSE_AUTO_REPEAT_EN is defined.
module key_pulse_debouncer #(
  parameter int unsigned TW            = 20,
  parameter int unsigned DB_CYCLES     = 50000,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_PERIOD = 100000
) (
  input  logic clk,
  input  logic mr,
  input  logic key_in,
  output logic en_pulse,
  output logic key_level
);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_HELD         = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  localparam logic [TW-1:0] DB_LAST = TW'(DB_CYCLES - 1);

  // Reject configurations the timers cannot represent.
  if ((DB_CYCLES < 2) || (64'(DB_CYCLES) > ((64'(1) << TW) - 64'(1))) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_cfg
    $error("key_pulse_debouncer: illegal timer parameters");
  end

  logic          sync1_q, sync2_q;
  logic          key_s;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          press_pulse_d;
  logic          en_pulse_q, en_pulse_d;
  logic          key_level_q, key_level_d;

  always_ff @(posedge clk) begin
    if (mr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q;

  always_ff @(posedge clk) begin
    if (mr) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      en_pulse_q  <= 1'b0;
      key_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      en_pulse_q  <= en_pulse_d;
      key_level_q <= key_level_d;
    end
  end

  // Every waiting state exits at DB_LAST, so the timer never wraps.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    press_pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key_s) begin
          state_d = S_PRESS_WAIT;
          timer_d = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!key_s) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d       = S_HELD;
          timer_d       = '0;
          press_pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HELD: begin
        if (!key_s) begin
          state_d = S_RELEASE_WAIT;
          timer_d = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (key_s) begin
          state_d = S_HELD;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
    key_level_d = (state_d == S_HELD) || (state_d == S_RELEASE_WAIT);
  end

`ifdef KEY_PULSE_AUTO_REPEAT_EN
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0] rpt_q, rpt_d;
  logic          rpt_first_q, rpt_first_d;
  logic          rpt_fire;

  always_ff @(posedge clk) begin
    if (mr) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end

  // First interval is the repeat delay, later ones the repeat period; cleared outside HELD.
  always_comb begin
    rpt_d       = '0;
    rpt_first_d = 1'b1;
    rpt_fire    = 1'b0;
    if ((state_q == S_HELD) && key_s) begin
      rpt_first_d = rpt_first_q;
      if (rpt_q == (rpt_first_q ? RD_LAST : RP_LAST)) begin
        rpt_fire    = !en_pulse_q;
        rpt_d       = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_d = rpt_q + TW'(1);
      end
    end
  end

  assign en_pulse_d = press_pulse_d | rpt_fire;
`else
  assign en_pulse_d = press_pulse_d;
`endif

  assign en_pulse  = en_pulse_q;
  assign key_level = key_level_q;

endmodule

// File: tb/tb_key_pulse_debouncer.sv
// Scoreboard bench for key_pulse_debouncer: expected pulse and level-change edges are
// queued by the stimulus and popped by an independent negedge monitor.
module tb_key_pulse_debouncer;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  typedef struct {
    int   t_edge;
    logic val;
  } lvl_ev_t;

  logic clk = 1'b0;
  logic mr = 1'b1;
  logic key_in = 1'b0;
  logic en_pulse, key_level;

  int      edge_cnt = 0;
  int      checks = 0;
  int      failures = 0;
  int      pulse_q[$];
  lvl_ev_t lvl_q[$];
  lvl_ev_t ev;
  logic    mon_en = 1'b0;
  logic    prev_lvl = 1'b0;
  logic [3:0] cnt4 = 4'd0;
  int      co_cnt = 0;

  key_pulse_debouncer #(
    .TW(20), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .mr(mr), .key_in(key_in), .en_pulse(en_pulse), .key_level(key_level)
  );

  always #5 clk = ~clk;

  // Edge index and downstream 4-bit counter (shares mr and clk).
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (mr) cnt4 <= 4'd0;
    else if (en_pulse === 1'b1) begin
      if (cnt4 == 4'd15) co_cnt <= co_cnt + 1;
      cnt4 <= cnt4 + 4'd1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (en_pulse !== 1'b0) begin
        if (pulse_q.size() == 0) check("unexpected_pulse_at_edge", edge_cnt, -1);
        else check("pulse_edge", edge_cnt, pulse_q.pop_front());
      end
      if (key_level !== prev_lvl) begin
        if (lvl_q.size() == 0) check("unexpected_level_change_at_edge", edge_cnt, -1);
        else begin
          ev = lvl_q.pop_front();
          check("level_edge", edge_cnt, ev.t_edge);
          check("level_value", int'(key_level), int'(ev.val));
        end
        prev_lvl = key_level;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) tick();
  endtask

  task automatic exp_pulse(input int e);
    pulse_q.push_back(e);
  endtask

  task automatic exp_lvl(input int e, input logic v);
    lvl_ev_t x;
    x.t_edge = e;
    x.val    = v;
    lvl_q.push_back(x);
  endtask

  logic bounce [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int n, m, r, x;
    // Reset for two cycles.
    mr = 1'b1; key_in = 1'b0;
    tick(); tick();
    check("reset_en_pulse", int'(en_pulse), 0);
    check("reset_key_level", int'(key_level), 0);
    mr = 1'b0;
    prev_lvl = 1'b0;
    mon_en = 1'b1;

    // Clean press and release.
    n = edge_cnt + 1;
    exp_pulse(n + DB + 2);
    exp_lvl(n + DB + 2, 1'b1);
    hold(1'b1, 10);
    check("counter_after_first_press", int'(cnt4), 1);
    m = edge_cnt + 1;
    exp_lvl(m + DB + 2, 1'b0);
    hold(1'b0, 10);

    // Glitches of 3 and DB samples are rejected; DB+1 samples are accepted.
    hold(1'b1, 3);
    hold(1'b0, 10);
    hold(1'b1, DB);
    hold(1'b0, 10);
    check("glitch_key_level", int'(key_level), 0);
    check("glitch_counter", int'(cnt4), 1);
    n = edge_cnt + 1;
    exp_pulse(n + DB + 2);
    exp_lvl(n + DB + 2, 1'b1);
    exp_lvl(n + DB + 1 + DB + 2, 1'b0);
    hold(1'b1, DB + 1);
    hold(1'b0, 12);
    check("min_press_counter", int'(cnt4), 2);

    // Release bounce: returns to HELD without a pulse, release count restarts.
    n = edge_cnt + 1;
    exp_pulse(n + DB + 2);
    exp_lvl(n + DB + 2, 1'b1);
    hold(1'b1, 8);
    for (int i = 0; i < 8; i++) hold(bounce[i], 1);
    m = edge_cnt + 1;
    exp_lvl(m + DB + 2, 1'b0);
    hold(1'b0, 10);
    check("bounce_counter", int'(cnt4), 3);

    // Reset in PRESS_WAIT with timer=2, key kept high.
    n = edge_cnt + 1;
    hold(1'b1, 5);
    mr = 1'b1;
    tick();
    check("midpress_reset_en_pulse", int'(en_pulse), 0);
    check("midpress_reset_key_level", int'(key_level), 0);
    check("midpress_reset_counter", int'(cnt4), 0);
    mr = 1'b0;
    r = edge_cnt + 1;
    exp_pulse(r + DB + 2);
    exp_lvl(r + DB + 2, 1'b1);
    hold(1'b1, 8);

    // Reset while HELD drops the level on the reset edge; key still high re-presses.
    mr = 1'b1;
    x = edge_cnt + 1;
    exp_lvl(x, 1'b0);
    tick();
    mr = 1'b0;
    r = edge_cnt + 1;
    exp_pulse(r + DB + 2);
    exp_lvl(r + DB + 2, 1'b1);
    hold(1'b1, 8);
    m = edge_cnt + 1;
    exp_lvl(m + DB + 2, 1'b0);
    hold(1'b0, 10);

    // Reset on the terminal-count edge suppresses the pulse.
    n = edge_cnt + 1;
    hold(1'b1, DB + 2);
    mr = 1'b1;
    tick();
    check("terminal_reset_en_pulse", int'(en_pulse), 0);
    mr = 1'b0;
    r = edge_cnt + 1;
    exp_pulse(r + DB + 2);
    exp_lvl(r + DB + 2, 1'b1);
    hold(1'b1, 8);
    check("after_terminal_reset_counter", int'(cnt4), 1);
    m = edge_cnt + 1;
    exp_lvl(m + DB + 2, 1'b0);
    hold(1'b0, 10);

    // Sixteen presses wrap the downstream counter once.
    mr = 1'b1;
    tick();
    mr = 1'b0;
    check("pre16_counter", int'(cnt4), 0);
    for (int i = 0; i < 16; i++) begin
      n = edge_cnt + 1;
      exp_pulse(n + DB + 2);
      exp_lvl(n + DB + 2, 1'b1);
      exp_lvl(n + 8 + DB + 2, 1'b0);
      hold(1'b1, 8);
      hold(1'b0, 8);
    end
    check("wrap_counter", int'(cnt4), 0);
    check("wrap_co_count", co_cnt, 1);

`ifdef KEY_PULSE_AUTO_REPEAT_EN
    // Auto-repeat: press pulse at P, repeats at P+10, P+15 ... P+30.
    n = edge_cnt + 1;
    exp_pulse(n + DB + 2);
    exp_lvl(n + DB + 2, 1'b1);
    for (int k = 0; k <= 4; k++) exp_pulse(n + DB + 2 + RD + k * RP);
    hold(1'b1, DB + 2 + 31);
    m = edge_cnt + 1;
    exp_lvl(m + DB + 2, 1'b0);
    hold(1'b0, 10);
`endif

    hold(1'b0, 5);
    check("pulse_queue_drained", pulse_q.size(), 0);
    check("level_queue_drained", lvl_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
